cpu_fetch_stage: RTL and testbench

//  Instruction-fetch stage feeding the decode stage inside cpu_top. Owns the PC,

---
 rtl/cpu_fetch_stage_pkg.sv | 27 ++
 rtl/cpu_fetch_stage_fifo.sv | 68 ++++++
 rtl/cpu_fetch_stage.sv | 83 ++++++++
 tb/tb_cpu_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_stage_pkg.sv
// rtl/cpu_fetch_stage_pkg.sv - shared widths, fetch FSM encodings and next-state helper
package cpu_fetch_stage_pkg;

   localparam int INSTR_W = 32;
   localparam int FS_W    = 2;

   localparam logic [FS_W-1:0] FS_RUN   = 2'd0;
   localparam logic [FS_W-1:0] FS_WAIT  = 2'd1;
   localparam logic [FS_W-1:0] FS_FLUSH = 2'd2;

   // A redirect never cancels the single outstanding request; it only marks its response as wrong-path.
   function automatic logic [FS_W-1:0] fs_next(input logic [FS_W-1:0] state,
                                                input logic accept,
                                                input logic rsp,
                                                input logic redirect);
      logic [FS_W-1:0] nxt;
      nxt = FS_RUN;
      case (state)
         FS_RUN:   nxt = accept ? (redirect ? FS_FLUSH : FS_WAIT) : FS_RUN;
         FS_WAIT:  nxt = rsp ? FS_RUN : (redirect ? FS_FLUSH : FS_WAIT);
         FS_FLUSH: nxt = rsp ? FS_RUN : FS_FLUSH;
         default:  nxt = FS_RUN;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/cpu_fetch_stage_fifo.sv
// rtl/cpu_fetch_stage_fifo.sv - small synchronous FIFO of {pc, instr} with flush and occupancy count
module cpu_fetch_stage_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [DATA_W-1:0]          push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [DATA_W-1:0]          head_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Issue is gated on free space, so a push into a full buffer means the control logic is broken.
   always_ff @(posedge clk) begin
      if (!reset && !flush_i) begin
         assert (!(push_i && count_q == (AW+1)'(DEPTH))) else $error("fetch fifo overflow");
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/cpu_fetch_stage.sv
// rtl/cpu_fetch_stage.sv - fetch stage: PC, single-outstanding imem request FSM, redirect/flush, decode buffer
module cpu_fetch_stage
   import cpu_fetch_stage_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [XLEN-1:0]    if_pc,
   output logic [INSTR_W-1:0] if_instr,
   output logic [XLEN-1:0]    pc_out
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [FS_W-1:0]         state_q, state_d;
   logic [XLEN-1:0]         pc_q, pc_d;
   logic [XLEN-1:0]         req_pc_q, req_pc_d;
   logic [CW-1:0]           count;
   logic [XLEN+INSTR_W-1:0] head;
   logic                    accept, push, pop;

   assign imem_req_valid = !reset && (state_q == FS_RUN) && (count < CW'(FIFO_DEPTH));
   assign imem_req_addr  = pc_q;
   assign pc_out         = pc_q;
   assign accept         = imem_req_valid && imem_req_ready;

   // A redirect both flushes the buffer and suppresses any push/pop on the same edge.
   assign push = (state_q == FS_WAIT) && imem_rsp_valid && !redirect_valid;
   assign pop  = if_valid && if_ready && !redirect_valid;

   always_comb begin
      state_d  = fs_next(state_q, accept, imem_rsp_valid, redirect_valid);
      req_pc_d = accept ? pc_q : req_pc_q;
      pc_d     = pc_q;
      if (redirect_valid)
         pc_d = redirect_pc & ~XLEN'(3);
      else if (accept)
         pc_d = pc_q + XLEN'(4);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= FS_RUN;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   cpu_fetch_stage_fifo #(
      .DATA_W (XLEN + INSTR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i ({req_pc_q, imem_rsp_data}),
      .pop_i       (pop),
      .flush_i     (redirect_valid),
      .head_o      (head),
      .count_o     (count)
   );

   assign if_valid = (count != '0);
   assign if_pc    = if_valid ? head[XLEN+INSTR_W-1:INSTR_W] : '0;
   assign if_instr = if_valid ? head[INSTR_W-1:0] : '0;

endmodule

// File: tb/tb_cpu_fetch_stage.sv
// tb/tb_cpu_fetch_stage.sv - directed self-checking bench for cpu_fetch_stage with a latency-programmable imem model
module tb_cpu_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [31:0] pc_out;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] pop_pc[$];
   logic [31:0] pop_ins[$];
   logic [31:0] acc_log[$];
   bit          pend;
   int          cnt;
   int          lat;
   int          overlap;
   bit          last_acc;
   logic [31:0] paddr;

   cpu_fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .pc_out         (pc_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h00A0_0113;
      return {a[23:0], 8'h13};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %08h exp %08h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      pop_pc.delete();
      pop_ins.delete();
      acc_log.delete();
   endtask

   // One clock: sample handshakes before the edge, then advance the memory model.
   task automatic tick();
      bit          a;
      bit          p;
      logic [31:0] aa;
      a  = imem_req_valid && imem_req_ready;
      aa = imem_req_addr;
      p  = if_valid && if_ready && !redirect_valid && !reset;
      if (a) acc_log.push_back(aa);
      if (p) begin
         pop_pc.push_back(if_pc);
         pop_ins.push_back(if_instr);
      end
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (a) begin
         if (pend) overlap++;
         pend  = 1'b1;
         cnt   = lat;
         paddr = aa;
      end
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(paddr);
            pend           = 1'b0;
         end
      end
      last_acc = a;
   endtask

   task automatic wait_pops(input int n, input int budget);
      for (int i = 0; i < budget && pop_pc.size() < n; i++) tick();
   endtask

   initial begin
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if_ready       = 1'b1;
      pend           = 1'b0;
      cnt            = 0;
      lat            = 1;
      overlap        = 0;
      last_acc       = 1'b0;
      paddr          = '0;

      // reset state and first-fetch latency
      tick();
      tick();
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_instr", if_instr, 32'h0);
      reset = 1'b0;
      #1;
      check("t1_req_valid0", 32'(imem_req_valid), 32'd1);
      check("t1_addr0", imem_req_addr, 32'h0);
      tick();
      check("t1_wait_reqv", 32'(imem_req_valid), 32'd0);
      check("t1_pc_out4", pc_out, 32'h4);
      check("t1_ifv_early", 32'(if_valid), 32'd0);
      tick();
      check("t1_ifv", 32'(if_valid), 32'd1);
      check("t1_if_pc0", if_pc, 32'h0);
      check("t1_if_instr0", if_instr, 32'h0050_0093);
      check("t1_addr4", imem_req_addr, 32'h4);
      tick();
      tick();
      check("t1_if_pc4", if_pc, 32'h4);
      check("t1_if_instr4", if_instr, 32'h00A0_0113);
      check("t1_addr8", imem_req_addr, 32'h8);

      // decode stalled: buffer fills to two entries and issue stops
      if_ready = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("t2_full_reqv", 32'(imem_req_valid), 32'd0);
      check("t2_ifv", 32'(if_valid), 32'd1);
      check("t2_head_pc", if_pc, 32'h4);
      check("t2_pc_out", pc_out, 32'hC);
      clear_logs();
      if_ready = 1'b1;
      #1;
      wait_pops(2, 20);
      check("t2_npops", pop_pc.size(), 32'd2);
      check("t2_pc0", pop_pc[0], 32'h4);
      check("t2_ins0", pop_ins[0], 32'h00A0_0113);
      check("t2_pc1", pop_pc[1], 32'h8);
      check("t2_ins1", pop_ins[1], 32'h0000_0813);

      // redirect while waiting on a slow response
      lat = 3;
      last_acc = 1'b0;
      for (int i = 0; i < 20 && !last_acc; i++) tick();
      check("t3_saw_accept", 32'(last_acc), 32'd1);
      clear_logs();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      #1;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("t3_ifv_flushed", 32'(if_valid), 32'd0);
      check("t3_pc_out", pc_out, 32'h100);
      check("t3_flush_reqv", 32'(imem_req_valid), 32'd0);
      wait_pops(1, 30);
      check("t3_pc", pop_pc[0], 32'h100);
      check("t3_ins", pop_ins[0], 32'h0001_0013);
      check("t3_first_acc", acc_log[0], 32'h100);

      // redirect coincident with request accept, misaligned target
      lat = 1;
      for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
      check("t4_reqv", 32'(imem_req_valid), 32'd1);
      clear_logs();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      #1;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("t4_pc_out", pc_out, 32'h200);
      check("t4_ifv", 32'(if_valid), 32'd0);
      check("t4_flush_reqv", 32'(imem_req_valid), 32'd0);
      wait_pops(1, 20);
      check("t4_pc", pop_pc[0], 32'h200);
      check("t4_ins", pop_ins[0], 32'h0002_0013);
      check("t4_acc1", acc_log[1], 32'h200);

      // memory back-pressure then 3-cycle response latency
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      #1;
      tick();
      redirect_valid = 1'b0;
      #1;
      for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
      check("t5_addr", imem_req_addr, 32'h300);
      check("t5_pc_out", pc_out, 32'h300);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_held_v", 32'(imem_req_valid), 32'd1);
         check("t5_held_a", imem_req_addr, 32'h300);
      end
      clear_logs();
      imem_req_ready = 1'b1;
      lat            = 3;
      overlap        = 0;
      #1;
      wait_pops(3, 60);
      check("t5_pc0", pop_pc[0], 32'h300);
      check("t5_ins0", pop_ins[0], 32'h0003_0013);
      check("t5_pc1", pop_pc[1], 32'h304);
      check("t5_ins1", pop_ins[1], 32'h0003_0413);
      check("t5_pc2", pop_pc[2], 32'h308);
      check("t5_ins2", pop_ins[2], 32'h0003_0813);
      check("t5_overlap", 32'(overlap), 32'd0);

      // PC wrap, then reset while waiting
      lat = 1;
      clear_logs();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      #1;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("t6_pc_out", pc_out, 32'hFFFF_FFFC);
      wait_pops(2, 30);
      check("t6_pc0", pop_pc[0], 32'hFFFF_FFFC);
      check("t6_ins0", pop_ins[0], 32'hFFFF_FC13);
      check("t6_pc1", pop_pc[1], 32'h0);
      check("t6_ins1", pop_ins[1], 32'h0050_0093);
      lat = 3;
      last_acc = 1'b0;
      for (int i = 0; i < 20 && !last_acc; i++) tick();
      check("t6_saw_accept", 32'(last_acc), 32'd1);
      tick();
      reset = 1'b1;
      #1;
      check("t6_rst_ifv", 32'(if_valid), 32'd0);
      check("t6_rst_pc", pc_out, 32'h0);
      check("t6_rst_reqv", 32'(imem_req_valid), 32'd0);
      check("t6_rst_if_pc", if_pc, 32'h0);
      for (int i = 0; i < 4; i++) tick();
      check("t6_rst_ifv_late", 32'(if_valid), 32'd0);
      reset = 1'b0;
      lat   = 1;
      clear_logs();
      #1;
      check("t6_post_reqv", 32'(imem_req_valid), 32'd1);
      check("t6_post_addr", imem_req_addr, 32'h0);
      wait_pops(1, 20);
      check("t6_post_pc", pop_pc[0], 32'h0);
      check("t6_post_ins", pop_ins[0], 32'h0050_0093);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
